// File: rtl/dvp_tx.sv
// dvp_tx: serialises a valid/ready RGB888 pixel stream into framed DVP timing
// (pclk = clk/2, 3 bytes per pixel in R,G,B order, one byte per pclk slot).
// Optional colour-bar source: define DVP_TX_PATTERN_EN to add input pattern_en.
module dvp_tx #(
    parameter int WIDTH   = 1280,
    parameter int HEIGHT  = 720,
    parameter int H_BLANK = 64,
    parameter int V_SYNC  = 4,
    parameter int V_BACK  = 16,
    parameter int V_FRONT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef DVP_TX_PATTERN_EN
    input  logic        pattern_en,
`endif
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int L      = WIDTH * 3 + H_BLANK;
    localparam int V_SB   = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_MAX  = (V_SB > V_FRONT) ? V_SB : V_FRONT;
    localparam int C_MAX  = (V_MAX > 1) ? V_MAX * L : L;
    localparam int CW     = (C_MAX > 1) ? $clog2(C_MAX) : 1;
    localparam int RW     = (HEIGHT > 0) ? $clog2(HEIGHT + 1) : 1;

    localparam logic [CW-1:0] SYNC_LAST  = CW'(V_SYNC * L - 1);
    localparam logic [CW-1:0] BACK_LAST  = CW'(V_BACK * L - 1);
    localparam logic [CW-1:0] FRONT_LAST = CW'(V_FRONT * L - 1);
    localparam logic [CW-1:0] ACT_LAST   = CW'(WIDTH * 3 - 1);
    localparam logic [CW-1:0] HBL_LAST   = CW'(H_BLANK - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
    localparam bit            HAS_BACK   = (V_BACK > 0);
    localparam bit            HAS_FRONT  = (V_FRONT > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_HBLANK,
        S_VFRONT
    } state_t;

    state_t          state_q;
    logic            pclk_q;
    logic            vsync_q;
    logic            href_q;
    logic [7:0]      data_q;
    logic            pix_ready_q;
    logic            busy_q;
    logic            frame_done_q;
    logic            underrun_q;
    logic            start_pend_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [1:0]      byte_q;
    logic [15:0]     gb_q;

    logic            col_last;
    logic            starts_r;
    logic            pix_ok;
    logic [23:0]     pix_word;

`ifdef DVP_TX_PATTERN_EN
    localparam int BAR_W = (WIDTH >= 8) ? WIDTH / 8 : 1;
    localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

    logic [2:0]      bar_q;
    logic [BCW-1:0]  bar_cnt_q;
    logic [2:0]      cur_bar;
    logic [BCW-1:0]  cur_cnt;
`endif

    assign pclk       = pclk_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign data       = data_q;
    assign pix_ready  = pix_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

    // End-of-state detection and "next pclk fall starts an R byte" prediction.
    // State only changes on pclk falls, so the prediction made on the rising
    // edge still holds at the following fall.
    always_comb begin
        col_last = 1'b0;
        starts_r = 1'b0;
        case (state_q)
            S_VSYNC: begin
                col_last = (col_q == SYNC_LAST);
                starts_r = col_last & ~HAS_BACK;
            end
            S_VBACK: begin
                col_last = (col_q == BACK_LAST);
                starts_r = col_last;
            end
            S_ACTIVE: begin
                col_last = (col_q == ACT_LAST);
                starts_r = (byte_q == 2'd2) & ~col_last;
            end
            S_HBLANK: begin
                col_last = (col_q == HBL_LAST);
                starts_r = col_last & (row_q != ROW_LAST);
            end
            S_VFRONT: begin
                col_last = (col_q == FRONT_LAST);
            end
            default: begin
                col_last = 1'b0;
            end
        endcase
    end

    // Pixel source selection: handshake stream, or colour bars when enabled.
    always_comb begin
        pix_ok   = pix_ready_q & pix_valid;
        pix_word = pix_data;
`ifdef DVP_TX_PATTERN_EN
        cur_bar  = (state_q == S_ACTIVE) ? bar_q : 3'd0;
        cur_cnt  = (state_q == S_ACTIVE) ? bar_cnt_q : '0;
        if (pattern_en) begin
            pix_ok   = 1'b1;
            pix_word = {{8{~cur_bar[1]}}, {8{~cur_bar[2]}}, {8{~cur_bar[0]}}};
        end
`endif
    end

    // Frame FSM with registered DVP outputs; timing advances on pclk falls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pclk_q       <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            pix_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            start_pend_q <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            byte_q       <= '0;
            gb_q         <= '0;
`ifdef DVP_TX_PATTERN_EN
            bar_q        <= '0;
            bar_cnt_q    <= '0;
`endif
        end else begin
            pclk_q       <= ~pclk_q;
            frame_done_q <= 1'b0;
            if (state_q == S_IDLE && start) begin
                start_pend_q <= 1'b1;
            end
            if (!pclk_q) begin
`ifdef DVP_TX_PATTERN_EN
                pix_ready_q <= starts_r & ~pattern_en;
`else
                pix_ready_q <= starts_r;
`endif
            end else begin
                pix_ready_q <= 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (start_pend_q) begin
                            state_q      <= S_VSYNC;
                            vsync_q      <= 1'b1;
                            busy_q       <= 1'b1;
                            underrun_q   <= 1'b0;
                            start_pend_q <= 1'b0;
                            col_q        <= '0;
                            row_q        <= '0;
                        end
                    end
                    S_VSYNC: begin
                        if (col_last) begin
                            vsync_q <= 1'b0;
                            col_q   <= '0;
                            if (HAS_BACK) begin
                                state_q <= S_VBACK;
                            end else begin
                                state_q <= S_ACTIVE;
                                href_q  <= 1'b1;
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                    S_VBACK: begin
                        if (col_last) begin
                            state_q <= S_ACTIVE;
                            href_q  <= 1'b1;
                            col_q   <= '0;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                    S_ACTIVE: begin
                        if (col_last) begin
                            state_q <= S_HBLANK;
                            href_q  <= 1'b0;
                            data_q  <= '0;
                            col_q   <= '0;
                        end else begin
                            col_q <= col_q + CW'(1);
                            if (byte_q != 2'd2) begin
                                byte_q <= byte_q + 2'd1;
                                data_q <= (byte_q == 2'd0) ? gb_q[15:8] : gb_q[7:0];
                            end
                        end
                    end
                    S_HBLANK: begin
                        if (col_last) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                row_q <= '0;
                                if (HAS_FRONT) begin
                                    state_q <= S_VFRONT;
                                end else begin
                                    state_q      <= S_IDLE;
                                    busy_q       <= 1'b0;
                                    frame_done_q <= 1'b1;
                                end
                            end else begin
                                row_q   <= row_q + RW'(1);
                                state_q <= S_ACTIVE;
                                href_q  <= 1'b1;
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                    S_VFRONT: begin
                        if (col_last) begin
                            state_q      <= S_IDLE;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            col_q        <= '0;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
                // R byte goes out on the same edge the pixel is taken; G/B are
                // parked in gb_q. A missing pixel is sent as zeros, never stalled.
                if (starts_r) begin
                    byte_q <= 2'd0;
                    if (pix_ok) begin
                        data_q <= pix_word[23:16];
                        gb_q   <= pix_word[15:0];
                    end else begin
                        data_q     <= '0;
                        gb_q       <= '0;
                        underrun_q <= 1'b1;
                    end
`ifdef DVP_TX_PATTERN_EN
                    if (cur_cnt == BAR_LAST) begin
                        bar_cnt_q <= '0;
                        bar_q     <= cur_bar + 3'd1;
                    end else begin
                        bar_cnt_q <= cur_cnt + BCW'(1);
                        bar_q     <= cur_bar;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_tx.sv
// Directed self-checking bench for dvp_tx with a small frame
// (WIDTH=4, HEIGHT=2, H_BLANK=3, V_SYNC=V_BACK=V_FRONT=1, L=15 slots).
`timescale 1ns/1ps
module tb_dvp_tx;

    // Slot map from VSYNC entry (slot 0): vsync 0..14, vback 15..29,
    // line0 30..41 + blank 42..44, line1 45..56 + blank 57..59,
    // vfront 60..74, frame_done on the fall that would be slot 75.
    localparam int VS_END    = 15;
    localparam int LINE0     = 30;
    localparam int LINE1     = 45;
    localparam int FRAME_END = 75;
    localparam int DROP_SLOT = 36;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pix_valid = 1'b1;
    logic [23:0] pix_data = '0;
    logic        pix_ready, pclk, vsync, href, busy, frame_done, underrun;
    logic [7:0]  data;

    int total = 0;
    int bad = 0;

    logic [23:0] pixels [8] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC,
                                24'hDDEEFF, 24'h102030, 24'h405060, 24'h708090};

`ifdef DVP_TX_PATTERN_EN
    logic        pat_off = 1'b0;
    logic        pat_on = 1'b1;
    logic        p_start = 1'b0;
    logic        p_valid = 1'b0;
    logic [23:0] p_pix = 24'h123456;
    logic        p_ready, p_pclk, p_vsync, p_href, p_busy, p_done, p_under;
    logic [7:0]  p_data;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    dvp_tx #(
        .WIDTH(4), .HEIGHT(2), .H_BLANK(3), .V_SYNC(1), .V_BACK(1), .V_FRONT(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef DVP_TX_PATTERN_EN
        .pattern_en(pat_off),
`endif
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .pclk(pclk), .vsync(vsync), .href(href), .data(data), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

`ifdef DVP_TX_PATTERN_EN
    dvp_tx #(
        .WIDTH(16), .HEIGHT(1), .H_BLANK(2), .V_SYNC(1), .V_BACK(0), .V_FRONT(0)
    ) u_pat (
        .clk(clk), .rst_n(rst_n), .start(p_start), .pattern_en(pat_on),
        .pix_valid(p_valid), .pix_data(p_pix), .pix_ready(p_ready),
        .pclk(p_pclk), .vsync(p_vsync), .href(p_href), .data(p_data), .busy(p_busy),
        .frame_done(p_done), .underrun(p_under)
    );
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string ph, input int s, input logic pc, input logic vs,
                             input logic hr, input logic [7:0] d, input logic bz,
                             input logic pr, input logic fd, input logic ur);
        chk($sformatf("%s s%0d pclk", ph, s), pclk, pc);
        chk($sformatf("%s s%0d vsync", ph, s), vsync, vs);
        chk($sformatf("%s s%0d href", ph, s), href, hr);
        chk($sformatf("%s s%0d data", ph, s), data, d);
        chk($sformatf("%s s%0d busy", ph, s), busy, bz);
        chk($sformatf("%s s%0d pix_ready", ph, s), pix_ready, pr);
        chk($sformatf("%s s%0d frame_done", ph, s), frame_done, fd);
        chk($sformatf("%s s%0d underrun", ph, s), underrun, ur);
    endtask

    // Expected DVP line state during slot s of a frame (s<0: idle before start).
    task automatic model(input int s, input bit drop, input bit ur_before,
                         output logic vs, output logic hr, output logic [7:0] d,
                         output logic bz, output logic ur, output logic rr);
        int off;
        int p;
        int k;
        logic [23:0] px;
        vs = 1'b0; hr = 1'b0; d = 8'h00; bz = 1'b0; rr = 1'b0; ur = ur_before;
        if (s >= 0) begin
            bz  = (s < FRAME_END);
            vs  = (s < VS_END);
            ur  = drop && (s >= DROP_SLOT);
            off = -1;
            if (s >= LINE0 && s < LINE0 + 12) off = s - LINE0;
            else if (s >= LINE1 && s < LINE1 + 12) off = s - LINE1 + 12;
            if (off >= 0) begin
                hr = 1'b1;
                p  = off / 3;
                k  = off % 3;
                px = (drop && p == 2) ? 24'h000000 : pixels[p];
                d  = (k == 0) ? px[23:16] : (k == 1) ? px[15:8] : px[7:0];
                rr = (k == 0);
            end
        end
    endtask

    task automatic idle_slots(input int n, input logic ur);
        for (int i = 0; i < n; i++) begin
            tick();
            check_all("idle-rise", i, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ur);
            tick();
            check_all("idle-fall", i, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ur);
        end
    endtask

    // One frame from a start pulse; abort_at>=0 applies reset before that slot.
    task automatic run_frame(input bit drop, input bit mid_start, input int abort_at,
                             input bit ur_before);
        int pulses;
        int p;
        logic vs, hr, bz, ur, rr, vs1, hr1, bz1, ur1, rr1;
        logic [7:0] d, d1;
        pulses = 0;
        for (int s = 0; s <= FRAME_END; s++) begin
            if (s == 0 || (mid_start && s == 40)) start = 1'b1;
            if (s == abort_at) begin
                rst_n = 1'b0;
                tick();
                check_all("reset", s, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
                tick();
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            tick();
            model(s - 1, drop, ur_before, vs, hr, d, bz, ur, rr);
            model(s, drop, ur_before, vs1, hr1, d1, bz1, ur1, rr1);
            check_all("rise", s, 1'b1, vs, hr, d, bz, rr1, 1'b0, ur);
            if (pix_ready) begin
                p = pulses;
                pulses++;
                pix_data  = (p < 8) ? pixels[p] : 24'h000000;
                pix_valid = !(drop && p == 2);
            end else begin
                pix_data  = 24'hA5A5A5;
                pix_valid = 1'b1;
            end
            tick();
            start = 1'b0;
            check_all("fall", s, 1'b0, vs1, hr1, d1, bz1, 1'b0, (s == FRAME_END), ur1);
        end
        chk("pix_ready pulses per frame", pulses, 8);
        tick();
        chk("frame_done one clk wide", frame_done, 1'b0);
        tick();
    endtask

    initial begin
        // reset values
        tick();
        tick();
        check_all("por", 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        // free-running pclk, outputs quiet in IDLE (20 clk)
        idle_slots(10, 1'b0);
        // clean frame, pixels always valid
        run_frame(1'b0, 1'b0, -1, 1'b0);
        idle_slots(3, 1'b0);
        // pixel 2 missing, plus a start request while busy
        run_frame(1'b1, 1'b1, -1, 1'b0);
        // no queued frame; underrun stays set
        idle_slots(10, 1'b1);
        // accepted start clears underrun; reset during line 0
        run_frame(1'b0, 1'b0, 35, 1'b1);
        idle_slots(5, 1'b0);
        // full clean frame after mid-frame reset
        run_frame(1'b0, 1'b0, -1, 1'b0);
        idle_slots(2, 1'b0);
`ifdef DVP_TX_PATTERN_EN
        // colour bars: 16 px, 2 px per bar, vsync 0..49, line 50..97, done at 100
        p_start = 1'b1;
        for (int s = 0; s <= 100; s++) begin
            int off;
            logic [23:0] px;
            logic [7:0] eb;
            tick();
            chk($sformatf("pat s%0d pix_ready", s), p_ready, 1'b0);
            tick();
            p_start = 1'b0;
            eb = 8'h00;
            if (s >= 50 && s < 98) begin
                off = s - 50;
                px  = bars[(off / 3) / 2];
                eb  = (off % 3 == 0) ? px[23:16] : (off % 3 == 1) ? px[15:8] : px[7:0];
            end
            chk($sformatf("pat s%0d data", s), p_data, eb);
            chk($sformatf("pat s%0d href", s), p_href, (s >= 50 && s < 98));
            chk($sformatf("pat s%0d vsync", s), p_vsync, (s < 50));
            chk($sformatf("pat s%0d frame_done", s), p_done, (s == 100));
            chk($sformatf("pat s%0d underrun", s), p_under, 1'b0);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
